// File: rtl/counter_cmd_sched_pkg.sv
// Shared types for the counter command scheduler: op codes, FSM states and
// the default counter width.
package counter_sched_pkg;

    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_READ = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// searching ptr, ptr+1, ... modulo N_REQ.
module rr_arbiter import counter_sched_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    localparam logic [ID_W:0] N_L = (ID_W + 1)'(N_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // ptr < N_REQ, so ptr+i never exceeds 2*N_REQ-2 and one subtraction wraps it
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(i);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_cmd_sched.sv
// Round-robin scheduler sharing one up/down load counter among N_REQ
// requesters; holds the counter by reloading its own value when not stepping.
//
//   state   | meaning
//   IDLE    | offer one-hot grant, latch command on handshake
//   EXEC    | load / step / hold the counter for the latched command
//   RESP    | present resp_id and the resulting count until accepted
module counter_cmd_sched import counter_sched_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [CNT_W*N_REQ-1:0] req_arg,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [CNT_W-1:0]       resp_value,
    output logic                   cnt_load,
    output logic                   cnt_updown,
    output logic [CNT_W-1:0]       cnt_data,
    input  logic [CNT_W-1:0]       cnt_value
);

    localparam logic [ID_W:0] N_L = (ID_W + 1)'(N_REQ);

    sched_state_e     state;
    cmd_op_e          op_q;
    cmd_op_e          sel_op;
    logic [CNT_W-1:0] arg_q;
    logic [CNT_W-1:0] sel_arg;
    logic [CNT_W-1:0] remaining;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W:0]    inc;
    logic [N_REQ-1:0] grant;
    logic             handshake;
    logic             step_op;
    logic             stepping;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        grant_id = '0;
        sel_op   = OP_LOAD;
        sel_arg  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
                sel_op   = cmd_op_e'(req_op[2*i +: 2]);
                sel_arg  = req_arg[CNT_W*i +: CNT_W];
            end
        end
    end

    always_comb begin
        inc      = {1'b0, grant_id} + (ID_W + 1)'(1);
        next_ptr = (inc == N_L) ? '0 : inc[ID_W-1:0];
    end

    // Anything that is not an active step reloads the counter with itself
    assign step_op    = (op_q == OP_UP) || (op_q == OP_DOWN);
    assign stepping   = !rst && state == ST_EXEC && step_op && remaining != '0;
    assign cnt_load   = !stepping;
    assign cnt_updown = stepping && op_q == OP_UP;
    assign cnt_data   = (!rst && state == ST_EXEC && op_q == OP_LOAD) ? arg_q : cnt_value;

    assign resp_valid = (state == ST_RESP);
    assign resp_id    = id_q;
    assign resp_value = resp_valid ? cnt_value : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_q      <= OP_LOAD;
            arg_q     <= '0;
            remaining <= '0;
            id_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        op_q      <= sel_op;
                        arg_q     <= sel_arg;
                        remaining <= sel_arg;
                        id_q      <= grant_id;
                        rr_ptr    <= next_ptr;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (stepping) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_RESP;
                        end
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Bench for counter_cmd_sched with a behavioural 4-bit load counter attached;
// directed scenarios followed by randomized traffic against a reference model.
module tb_counter_cmd_sched;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_arg;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_value;
    logic           cnt_load;
    logic           cnt_updown;
    logic [W-1:0]   cnt_data;
    logic [W-1:0]   cnt_value;

    logic [1:0]     op_a  [N];
    logic [W-1:0]   arg_a [N];

    int tests = 0;
    int fails = 0;
    int mcnt  = 0;
    int mptr  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_op  = '0;
        req_arg = '0;
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2]  = op_a[i];
            req_arg[W*i +: W] = arg_a[i];
        end
    end

    // Stand-in for the existing counter: no enable, steps on every non-load cycle
    always_ff @(posedge clk) begin
        if (rst)             cnt_value <= '0;
        else if (cnt_load)   cnt_value <= cnt_data;
        else if (cnt_updown) cnt_value <= cnt_value + 4'd1;
        else                 cnt_value <= cnt_value - 4'd1;
    end

    counter_cmd_sched #(.N_REQ(N), .CNT_W(W), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_arg    (req_arg),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_value (resp_value),
        .cnt_load   (cnt_load),
        .cnt_updown (cnt_updown),
        .cnt_data   (cnt_data),
        .cnt_value  (cnt_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int id, input int op, input int arg);
        req_valid[id] = 1'b1;
        op_a[id]      = 2'(op);
        arg_a[id]     = 4'(arg);
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (mptr + i) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int model_result(input int op, input int arg, input int cur);
        case (op)
            0:       return arg;
            1:       return (cur + arg) % 16;
            2:       return (cur - arg + 16) % 16;
            default: return cur;
        endcase
    endfunction

    // Serve one grant from IDLE through response acceptance, holding resp_ready low 'hold' cycles
    task automatic transact(input int hold, output logic [N-1:0] gvec);
        int gid, eop, earg, eval, elat, esteps, lat, steps;
        #1;
        gid  = model_grant(req_valid);
        gvec = req_ready;
        chk("grant", req_ready, (gid < 0) ? 32'd0 : (32'd1 << gid));
        if (gid < 0) return;
        eop    = int'(op_a[gid]);
        earg   = int'(arg_a[gid]);
        eval   = model_result(eop, earg, mcnt);
        esteps = (eop == 1 || eop == 2) ? earg : 0;
        elat   = (esteps != 0) ? esteps + 1 : 2;
        tick();
        req_valid[gid] = 1'b0;
        op_a[gid]      = 2'($urandom_range(3));
        arg_a[gid]     = 4'($urandom_range(15));
        #1;
        lat   = 1;
        steps = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            chk("busy_ready", req_ready, 0);
            if (cnt_load === 1'b0) begin
                steps++;
                chk("updown", cnt_updown, (eop == 1) ? 32'd1 : 32'd0);
            end
            tick();
            lat++;
        end
        chk("latency", lat, elat);
        chk("steps", steps, esteps);
        chk("resp_id", resp_id, gid);
        chk("resp_value", resp_value, eval);
        mcnt = eval;
        mptr = (gid + 1) % N;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", resp_valid, 1);
            chk("hold_id", resp_id, gid);
            chk("hold_value", resp_value, eval);
            chk("hold_cnt", cnt_value, eval);
            chk("hold_load", cnt_load, 1);
            chk("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        #1;
        chk("accept_ready", req_ready, 0);
        tick();
        resp_ready = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i]  = '0;
            arg_a[i] = '0;
        end

        rst = 1'b1;
        tick();
        tick();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_value", resp_value, 0);
        chk("rst_cnt", cnt_value, 0);
        chk("rst_load", cnt_load, 1);
        chk("rst_data", cnt_data, cnt_value);
        req_valid = 4'b0101;
        #1;
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        post(0, 0, 9);
        transact(0, g);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold9", cnt_value, 9);
            chk("hold9_load", cnt_load, 1);
        end

        post(1, 0, 14);
        transact(0, g);
        post(1, 1, 3);
        transact(0, g);
        chk("wrap_up", cnt_value, 1);

        post(2, 0, 2);
        transact(0, g);
        post(2, 2, 0);
        transact(0, g);
        post(2, 3, 0);
        transact(0, g);
        chk("read2", cnt_value, 2);

        post(3, 3, 0);
        transact(0, g);
        for (int i = 0; i < N; i++) post(i, 3, 0);
        for (int k = 0; k < N; k++) begin
            transact(0, g);
            chk("rr_order", g, 32'd1 << k);
        end
        post(3, 3, 0);
        post(1, 3, 0);
        transact(0, g);
        chk("rr_after3", g, 4'b0010);
        transact(0, g);
        chk("rr_then3", g, 4'b1000);

        post(0, 1, 2);
        post(2, 0, 5);
        transact(5, g);
        transact(0, g);

        post(1, 1, 5);
        #1;
        chk("rst_mid_grant", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("rst_mid_step1", cnt_load, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_hold", cnt_load, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_resp", resp_valid, 0);
        chk("rst_mid_cnt", cnt_value, 0);
        mcnt = 0;
        mptr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid_quiet", cnt_value, 0);
            chk("rst_mid_noresp", resp_valid, 0);
        end
        post(2, 0, 7);
        transact(0, g);
        chk("after_rst_load", cnt_value, 7);

        repeat (60) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1) == 1)
                    post(i, int'($urandom_range(3)), int'($urandom_range(15)));
            end
            if ($urandom_range(5) == 0 && $countones(req_valid) > 1)
                req_valid[$urandom_range(N - 1)] = 1'b0;
            if (req_valid == '0)
                post(int'($urandom_range(N - 1)), int'($urandom_range(3)), int'($urandom_range(15)));
            transact(int'($urandom_range(2)), g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
